pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 38 +++
 rtl/pipeline_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared constants for the pipeline controller:
//   - stall bus encodings (bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM,
//     bit4 MEM/WB, bit5 WB)
//   - exception codes and the fixed exception handler address
//   - controller FSM state codes
//   - redirect_target(): selects the PC a flush redirects to
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    localparam int SIGNAL_BUS = 6;

    localparam logic [SIGNAL_BUS-1:0] STALL_NONE = 6'b000000;
    localparam logic [SIGNAL_BUS-1:0] STALL_IF   = 6'b000011;
    localparam logic [SIGNAL_BUS-1:0] STALL_ID   = 6'b000111;
    localparam logic [SIGNAL_BUS-1:0] STALL_EX   = 6'b001111;
    localparam logic [SIGNAL_BUS-1:0] STALL_MEM  = 6'b011111;
    localparam logic [SIGNAL_BUS-1:0] STALL_ALL  = 6'b111111;

    localparam logic [31:0] EXC_NONE               = 32'h00000000;
    localparam logic [31:0] EXC_ERET               = 32'h0000000e;
    localparam logic [31:0] EXCEPTION_HANDLER_ADDR = 32'h00000020;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_PEND  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    // ERET returns to the saved EPC; every other exception enters the handler.
    function automatic logic [31:0] redirect_target(input logic [31:0] code,
                                                    input logic [31:0] epc);
        return (code == EXC_ERET) ? epc : EXCEPTION_HANDLER_ADDR;
    endfunction

endpackage

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Central stall / flush controller for a 5-stage pipeline.
//
// Ports
//   clock                  in   rising-edge clock
//   reset                  in   synchronous, active-high
//   stall_request_from_if  in   IF stage hold request
//   stall_request_from_id  in   ID stage hold request
//   stall_request_from_ex  in   EX stage hold request
//   stall_request_from_mem in   MEM stage hold request
//   exception_type[31:0]   in   MEM-stage exception code, 0 = none
//   cp0_epc[31:0]          in   return address used by ERET
//   stall[5:0]             out  per-buffer hold (bit0 PC .. bit5 WB)
//   flush                  out  one-cycle clear of every pipeline buffer
//   new_pc[31:0]           out  redirect target, meaningful while flush=1
//   fsm_state              out  controller state, for observation
//   stall_cycles[31:0]     out  saturating count of stalled cycles
//                               (only with PIPELINE_CTRL_STALL_COUNT_EN)
//
// Build option
//   PIPELINE_CTRL_STALL_COUNT_EN  adds the stall_cycles counter and port.
//
// Behaviour summary
//   RUN/HOLD : stall follows the requests combinationally, deepest stage wins.
//   exception with MEM free  : stall all, flush on the next cycle.
//   exception with MEM busy  : PEND (stall all, exception latched) until MEM
//                              drops its request, then flush.
//   FLUSH    : one cycle, flush=1, stall=0, new exceptions ignored.
// ---------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall_request_from_if,
    input  logic                  stall_request_from_id,
    input  logic                  stall_request_from_ex,
    input  logic                  stall_request_from_mem,
    input  logic [31:0]           exception_type,
    input  logic [31:0]           cp0_epc,
    output logic [SIGNAL_BUS-1:0] stall,
    output logic                  flush,
    output logic [31:0]           new_pc,
`ifdef PIPELINE_CTRL_STALL_COUNT_EN
    output logic [31:0]           stall_cycles,
`endif
    output state_t                fsm_state
);

    state_t      state_q, state_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [31:0] exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;

    logic                  any_req;
    logic                  exc_seen;
    logic [SIGNAL_BUS-1:0] req_stall;

    assign any_req  = stall_request_from_if | stall_request_from_id |
                      stall_request_from_ex | stall_request_from_mem;
    assign exc_seen = (exception_type != EXC_NONE);

    // Holding a stage must also hold every stage in front of it, so the
    // deepest requester decides the whole bus.
    always_comb begin
        if (stall_request_from_mem)     req_stall = STALL_MEM;
        else if (stall_request_from_ex) req_stall = STALL_EX;
        else if (stall_request_from_id) req_stall = STALL_ID;
        else if (stall_request_from_if) req_stall = STALL_IF;
        else                            req_stall = STALL_NONE;
    end

    always_comb begin
        state_d    = state_q;
        stall      = STALL_NONE;
        flush_d    = 1'b0;
        new_pc_d   = new_pc_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;

        case (state_q)
            ST_RUN, ST_HOLD: begin
                if (exc_seen) begin
                    stall = STALL_ALL;
                    if (stall_request_from_mem) begin
                        // MEM is still busy: the flush would kill an access
                        // in flight, so remember the exception and wait.
                        state_d    = ST_PEND;
                        exc_code_d = exception_type;
                        epc_d      = cp0_epc;
                    end else begin
                        state_d  = ST_FLUSH;
                        flush_d  = 1'b1;
                        new_pc_d = redirect_target(exception_type, cp0_epc);
                    end
                end else begin
                    stall   = req_stall;
                    state_d = any_req ? ST_HOLD : ST_RUN;
                end
            end

            ST_PEND: begin
                stall = STALL_ALL;
                if (!stall_request_from_mem) begin
                    state_d    = ST_FLUSH;
                    flush_d    = 1'b1;
                    new_pc_d   = redirect_target(exc_code_q, epc_q);
                    exc_code_d = EXC_NONE;
                    epc_d      = 32'h0;
                end
            end

            ST_FLUSH: begin
                // Buffers are being cleared; anything presented this cycle
                // comes from an instruction that is being discarded.
                stall   = STALL_NONE;
                state_d = ST_RUN;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_RUN;
            flush_q    <= 1'b0;
            new_pc_q   <= 32'h0;
            exc_code_q <= EXC_NONE;
            epc_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            flush_q    <= flush_d;
            new_pc_q   <= new_pc_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    assign flush     = flush_q;
    assign new_pc    = new_pc_q;
    assign fsm_state = state_q;

`ifdef PIPELINE_CTRL_STALL_COUNT_EN
    logic [31:0] stall_cycles_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles_q <= 32'h0;
        end else if ((stall != STALL_NONE) && (stall_cycles_q != 32'hFFFFFFFF)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule
